// File: rtl/updown_counter_mux_display.sv
// Up/down modulo counter with load clamp, prescaler and wrap pulse, driving a
// scanned common-anode hex seven-segment display of the current count.
module updown_counter_mux_display #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 200,
  parameter int PRESCALE = 1,
  parameter int SCAN_DIV = 4,
  localparam int DIGITS  = (WIDTH + 3) / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic              activeLoad,
  input  logic [WIDTH-1:0]  load,
  output logic [WIDTH-1:0]  cnt,
  output logic              tc,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        sseg
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam int MAX_I = MODULUS - 1;
  localparam int PMAX_I = PRESCALE - 1;
  localparam int SMAX_I = SCAN_DIV - 1;
  localparam int DMAX_I = DIGITS - 1;

  localparam logic [WIDTH-1:0] MAX_V  = MAX_I[WIDTH-1:0];
  localparam logic [WIDTH:0]   MOD_V  = MODULUS[WIDTH:0];
  localparam logic [PW-1:0]    PMAX_V = PMAX_I[PW-1:0];
  localparam logic [SW-1:0]    SMAX_V = SMAX_I[SW-1:0];
  localparam logic [DW-1:0]    DMAX_V = DMAX_I[DW-1:0];

  logic [WIDTH-1:0]    cnt_reg;
  logic                tc_reg;
  logic [PW-1:0]       presc_reg;
  logic [SW-1:0]       scan_reg;
  logic [DW-1:0]       digit_reg;
  logic [DIGITS-1:0]   an_reg;
  logic [7:0]          sseg_reg;

  logic                tick;
  logic [WIDTH-1:0]    load_clamped;
  logic [DIGITS*4-1:0] cnt_pad;
  logic [3:0]          nib [DIGITS];

  assign tick = enable && (presc_reg == PMAX_V);

  // The extra top bit lets MODULUS == 2**WIDTH compare correctly (never clamps).
  assign load_clamped = ({1'b0, load} >= MOD_V) ? MAX_V : load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg   <= '0;
      tc_reg    <= 1'b0;
      presc_reg <= '0;
    end else if (activeLoad) begin
      cnt_reg   <= load_clamped;
      tc_reg    <= 1'b0;
      presc_reg <= '0;
    end else begin
      tc_reg <= 1'b0;
      if (enable) begin
        presc_reg <= (presc_reg == PMAX_V) ? '0 : presc_reg + 1'b1;
      end
      if (tick) begin
        if (mode) begin
          if (cnt_reg == MAX_V) begin
            cnt_reg <= '0;
            tc_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end else begin
          if (cnt_reg == '0) begin
            cnt_reg <= MAX_V;
            tc_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
      end
    end
  end

  // Scan timing free-runs so the display never freezes while counting is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_reg  <= '0;
      digit_reg <= '0;
    end else if (scan_reg == SMAX_V) begin
      scan_reg  <= '0;
      digit_reg <= (digit_reg == DMAX_V) ? '0 : digit_reg + 1'b1;
    end else begin
      scan_reg <= scan_reg + 1'b1;
    end
  end

  assign cnt_pad = (DIGITS * 4)'(cnt_reg);

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign nib[gi] = cnt_pad[4*gi +: 4];
    end
  endgenerate

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_reg   <= ~(DIGITS'(1));
      sseg_reg <= 8'hC0;
    end else begin
      an_reg   <= ~(DIGITS'(1) << digit_reg);
      sseg_reg <= hex7(nib[digit_reg]);
    end
  end

  assign cnt  = cnt_reg;
  assign tc   = tc_reg;
  assign an   = an_reg;
  assign sseg = sseg_reg;

endmodule

// File: tb/tb_updown_counter_mux_display.sv
// Drives three counter/display instances with directed and random stimulus and
// checks every cycle against an arithmetic model of counting and display scan.
module tb_updown_counter_mux_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        mode;
  logic        activeLoad;
  logic [11:0] ld;

  logic [7:0]  cnt_a, cnt_b, sseg_a, sseg_b, sseg_c;
  logic [11:0] cnt_c;
  logic        tc_a, tc_b, tc_c;
  logic [1:0]  an_a, an_b;
  logic [2:0]  an_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  string phase = "reset";

  // Instance 0: defaults, 1: PRESCALE=3, 2: WIDTH=12 full-range modulus.
  int p_w[3]  = '{8, 8, 12};
  int p_m[3]  = '{200, 200, 4096};
  int p_p[3]  = '{1, 3, 2};
  int p_s[3]  = '{4, 4, 3};
  int p_d[3]  = '{2, 2, 3};

  int m_cnt[3], m_tc[3], m_presc[3], m_scan[3], m_dig[3], m_an[3], m_seg[3];

  logic [7:0] hex_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  updown_counter_mux_display #(.WIDTH(8), .MODULUS(200), .PRESCALE(1), .SCAN_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .activeLoad(activeLoad),
    .load(ld[7:0]), .cnt(cnt_a), .tc(tc_a), .an(an_a), .sseg(sseg_a));

  updown_counter_mux_display #(.WIDTH(8), .MODULUS(200), .PRESCALE(3), .SCAN_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .activeLoad(activeLoad),
    .load(ld[7:0]), .cnt(cnt_b), .tc(tc_b), .an(an_b), .sseg(sseg_b));

  updown_counter_mux_display #(.WIDTH(12), .MODULUS(4096), .PRESCALE(2), .SCAN_DIV(3)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .activeLoad(activeLoad),
    .load(ld), .cnt(cnt_c), .tc(tc_c), .an(an_c), .sseg(sseg_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_tc[i] = 0; m_presc[i] = 0; m_scan[i] = 0; m_dig[i] = 0;
      m_an[i] = ((1 << p_d[i]) - 1) & ~1;
      m_seg[i] = 8'hC0;
    end
  endtask

  // Advance every model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int nibv, ldv;
      nibv = (m_cnt[i] >> (4 * m_dig[i])) & 15;
      m_an[i] = ((1 << p_d[i]) - 1) & ~(1 << m_dig[i]);
      m_seg[i] = int'(hex_tab[nibv]);
      m_scan[i] = m_scan[i] + 1;
      if (m_scan[i] == p_s[i]) begin
        m_scan[i] = 0;
        m_dig[i] = (m_dig[i] + 1) % p_d[i];
      end
      m_tc[i] = 0;
      ldv = int'(ld) & ((1 << p_w[i]) - 1);
      if (activeLoad) begin
        m_cnt[i] = (ldv >= p_m[i]) ? p_m[i] - 1 : ldv;
        m_presc[i] = 0;
      end else if (enable) begin
        m_presc[i] = m_presc[i] + 1;
        if (m_presc[i] == p_p[i]) begin
          m_presc[i] = 0;
          if (mode) begin
            m_tc[i] = (m_cnt[i] == p_m[i] - 1) ? 1 : 0;
            m_cnt[i] = (m_cnt[i] + 1) % p_m[i];
          end else begin
            m_tc[i] = (m_cnt[i] == 0) ? 1 : 0;
            m_cnt[i] = (m_cnt[i] + p_m[i] - 1) % p_m[i];
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk({phase, "_cnt_a"}, 32'(cnt_a), m_cnt[0]);
    chk({phase, "_tc_a"}, 32'(tc_a), m_tc[0]);
    chk({phase, "_an_a"}, 32'(an_a), m_an[0]);
    chk({phase, "_sseg_a"}, 32'(sseg_a), m_seg[0]);
    chk({phase, "_cnt_b"}, 32'(cnt_b), m_cnt[1]);
    chk({phase, "_tc_b"}, 32'(tc_b), m_tc[1]);
    chk({phase, "_an_b"}, 32'(an_b), m_an[1]);
    chk({phase, "_sseg_b"}, 32'(sseg_b), m_seg[1]);
    chk({phase, "_cnt_c"}, 32'(cnt_c), m_cnt[2]);
    chk({phase, "_tc_c"}, 32'(tc_c), m_tc[2]);
    chk({phase, "_an_c"}, 32'(an_c), m_an[2]);
    chk({phase, "_sseg_c"}, 32'(sseg_c), m_seg[2]);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    $display("cyc %0d %s en=%b mode=%b ld=%b/%h cnt=%h/%h/%h tc=%b%b%b an=%b/%b/%b sseg=%h/%h/%h",
             cyc, phase, enable, mode, activeLoad, ld, cnt_a, cnt_b, cnt_c, tc_a, tc_b, tc_c,
             an_a, an_b, an_c, sseg_a, sseg_b, sseg_c);
    check_all();
  endtask

  // Pull reset between clock edges and check the outputs clear without an edge.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    $display("async reset at %0t (%s)", $time, phase);
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n0, n1, n2;
    rst = 1'b0; enable = 1'b0; mode = 1'b1; activeLoad = 1'b0; ld = '0;
    model_reset();
    #12;
    check_all();
    chk("reset_an_a", 32'(an_a), 32'h2);
    chk("reset_sseg_a", 32'(sseg_a), 32'hC0);
    @(negedge clk);
    rst = 1'b1;

    phase = "t1";
    ld = 12'h037; activeLoad = 1'b1; step();
    activeLoad = 1'b0; step();
    chk("t1_loaded", 32'(cnt_a), 32'h37);
    async_reset();
    chk("t1_rst_cnt", 32'(cnt_a), 32'h0);
    chk("t1_rst_an", 32'(an_a), 32'h2);
    chk("t1_rst_sseg", 32'(sseg_a), 32'hC0);

    phase = "t2";
    ld = 12'd198; mode = 1'b1; enable = 1'b1; activeLoad = 1'b1; step();
    activeLoad = 1'b0;
    chk("t2_load", 32'(cnt_a), 32'd198);
    step(); chk("t2_199", 32'(cnt_a), 32'd199); chk("t2_tc_199", 32'(tc_a), 32'd0);
    step(); chk("t2_wrap", 32'(cnt_a), 32'd0);   chk("t2_tc_wrap", 32'(tc_a), 32'd1);
    step(); chk("t2_one", 32'(cnt_a), 32'd1);    chk("t2_tc_one", 32'(tc_a), 32'd0);

    phase = "t3";
    ld = 12'd1; mode = 1'b0; activeLoad = 1'b1; step();
    activeLoad = 1'b0;
    chk("t3_load", 32'(cnt_a), 32'd1);
    step(); chk("t3_zero", 32'(cnt_a), 32'd0);   chk("t3_tc_zero", 32'(tc_a), 32'd0);
    step(); chk("t3_wrap", 32'(cnt_a), 32'hC7);  chk("t3_tc_wrap", 32'(tc_a), 32'd1);
    step(); chk("t3_198", 32'(cnt_a), 32'd198);  chk("t3_tc_198", 32'(tc_a), 32'd0);
    ld = 12'd5; activeLoad = 1'b1; step(); step();
    chk("t3_hold_load", 32'(cnt_a), 32'd5);
    chk("t3_hold_tc", 32'(tc_a), 32'd0);
    activeLoad = 1'b0;

    phase = "t4";
    ld = 12'd250; enable = 1'b0; activeLoad = 1'b1; step();
    activeLoad = 1'b0;
    chk("t4_clamp", 32'(cnt_a), 32'd199);
    chk("t4_clamp_tc", 32'(tc_a), 32'd0);
    repeat (20) step();
    chk("t4_hold", 32'(cnt_a), 32'd199);
    ld = 12'd42; activeLoad = 1'b1; step();
    activeLoad = 1'b0;
    chk("t4_load_noen", 32'(cnt_a), 32'd42);

    phase = "t5";
    ld = 12'd0; mode = 1'b1; enable = 1'b1; activeLoad = 1'b1; step();
    activeLoad = 1'b0;
    step(); step(); chk("t5_wait", 32'(cnt_b), 32'd0);
    step(); chk("t5_step1", 32'(cnt_b), 32'd1);
    step();
    enable = 1'b0; step(); step();
    enable = 1'b1; step(); chk("t5_delayed", 32'(cnt_b), 32'd1);
    step(); chk("t5_step2", 32'(cnt_b), 32'd2);

    phase = "t6";
    ld = 12'h0B7; enable = 1'b0; activeLoad = 1'b1; step();
    activeLoad = 1'b0;
    step(); step();
    n0 = 0; n1 = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (an_a == 2'b10 && sseg_a == 8'hF8) n0++;
      if (an_a == 2'b01 && sseg_a == 8'h83) n1++;
    end
    chk("t6_digit0_cycles", 32'(n0), 32'd8);
    chk("t6_digit1_cycles", 32'(n1), 32'd8);
    ld = 12'h0A5; activeLoad = 1'b1; step();
    activeLoad = 1'b0;
    step(); step();
    n2 = 0;
    for (int k = 0; k < 18; k++) begin
      step();
      if (an_c == 3'b011 && sseg_c == 8'hC0) n2++;
    end
    chk("t6_digit2_zero", 32'(n2), 32'd6);

    phase = "rand";
    for (int k = 0; k < 800; k++) begin
      enable = ($urandom_range(0, 3) != 0);
      mode = ($urandom_range(0, 5) != 0) ? mode : ~mode;
      activeLoad = ($urandom_range(0, 29) == 0);
      ld = 12'($urandom);
      if ($urandom_range(0, 149) == 0) async_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_mux_display.md
Name: updown_counter_mux_display

Overview:
Parametrised up/down counter with synchronous load, programmable modulus, count prescaler and terminal-count pulse. Drives a time-multiplexed multi-digit hexadecimal seven-segment display of the current count. Successor to the single-digit 4-bit lab counter. Sits between board switches/buttons and the board's common-anode display.

Parameters:
WIDTH, 8, counter width in bits (4..16).
MODULUS, 200, count range 0..MODULUS-1; legal 2..2^WIDTH.
PRESCALE, 1, enabled clock cycles per count step; 1 means step every enabled cycle.
SCAN_DIV, 4, clock cycles each digit stays lit; must be at least 1.
DIGITS, (WIDTH+3)/4, number of hex digits displayed; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
enable  input  1  count enable; gates the prescaler
mode  input  1  1 = count up, 0 = count down
activeLoad  input  1  synchronous load strobe
load  input  WIDTH  load value
cnt  output  WIDTH  registered count
tc  output  1  one-cycle terminal-count (wrap) pulse
an  output  DIGITS  digit select, one-hot active-low
sseg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1

Behaviour:
- Reset (rst=0, asynchronous, no clock required): cnt=0, tc=0, prescaler=0, scan counter=0, digit index=0, an = all ones except bit0=0, sseg=8'hC0.
- Priority at each clk edge: activeLoad, then count step.
- Load: applies when activeLoad=1, independent of enable. cnt <= load, or MODULUS-1 if load >= MODULUS (clamp). Prescaler cleared. tc=0 that cycle.
- Prescaler: with enable=1 it counts 0..PRESCALE-1 and wraps. tick = enable and (prescaler == PRESCALE-1). With enable=0 the prescaler holds and tick=0.
- On tick, up (mode=1): if cnt == MODULUS-1 then cnt <= 0 and tc <= 1, else cnt+1.
- On tick, down (mode=0): if cnt == 0 then cnt <= MODULUS-1 and tc <= 1, else cnt-1.
- tc: registered; 1 for exactly the cycle in which the wrapped value first appears on cnt, else 0.
- mode sampled each tick; changing direction mid-run is legal and takes effect at the next tick.
- Display scan: scan counter runs every clock (unaffected by enable or load) over 0..SCAN_DIV-1. On wrap, digit index advances 0..DIGITS-1, then wraps to 0.
- Display outputs: an and sseg are registered from the current digit index and the current cnt, giving one cycle of latency after either changes.
- Digit mapping: digit i shows nibble cnt[4i+3:4i]; bits above WIDTH read as 0.
- Hex patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Reset asserted mid-count or mid-scan: all state returns to reset values immediately. Counting resumes on the first clock after rst deasserts.

Test Plan:
(All with defaults unless stated; clk period 10.)
1. Async reset: from cnt=8'h37, pull rst low between edges -> cnt=0, tc=0, an=2'b10, sseg=8'hC0 with no clock edge.
2. Up wrap: load 198, mode=1, enable=1 -> cnt 198,199,0,1; tc=1 only in the cycle cnt=0.
3. Down wrap: load 1, mode=0 -> cnt 1,0,199 (8'hC7),198; tc=1 only in the cycle cnt=199. Load 5 with activeLoad held over one tick edge -> cnt=5 and tc=0 on that edge.
4. Clamp and enable: load 250 -> cnt=199, no tc. With enable=0, cnt holds over 20 cycles; load 42 still lands.
5. Prescaler: PRESCALE=3 instance, enable=1, mode=1 from 0 -> cnt steps every 3rd cycle. enable low for 2 cycles mid-period -> step delayed by exactly 2 cycles.
6. Display: hold cnt=8'hB7 -> an=2'b10 with sseg=8'hF8 for 4 cycles, then an=2'b01 with sseg=8'h83 for 4 cycles, repeating. WIDTH=12 instance with cnt=12'h0A5 -> third digit shows 8'hC0.
